frame_readout_ctrl: RTL and testbench
=====================================

// Module: frame_readout_ctrl
// PURPOSE
//  Sequences readout of one captured frame from line_buffer to uart_send on a host command byte.
//  Drives the line-buffer line select, column address and ready-flag release.
//  Emits a 2-byte frame header, then each line's pixels (full or 2x2-decimated), optionally a per-line checksum.
//  Replaces the ad-hoc readout logic in the top level; sits between uart_receive/line_buffer and uart_send.
// PARAMETERS
//  H  752  pixels per line (column count)
//  V  480  lines per frame
// PORTS
//  CLK              in   1            system clock
//  RST              in   1            synchronous, active-high reset
//  CMD_DATA         in   8            received command byte
//  CMD_VALID        in   1            1-cycle strobe, CMD_DATA valid
//  LINE_READY       in   1            line buffer holds the whole SELECTED_LINE
//  PIXEL_DATA       in   8            line buffer read data, valid 1 cycle after SELECTED_COLUMN changes
//  TX_IDLE          in   1            uart_send idle
//  SELECTED_LINE    out  $clog2(V)    line requested from line buffer
//  SELECTED_COLUMN  out  $clog2(H)    line buffer read address
//  RELEASE_LINE     out  1            clears line buffer ready flag
//  TX_DATA          out  8            byte to uart_send
//  TX_DATA_READY    out  1            1-cycle strobe to uart_send
//  BUSY             out  1            frame transfer in progress
// BEHAVIOUR
//  Reset: SELECTED_LINE=0, SELECTED_COLUMN=0, TX_DATA=0, TX_DATA_READY=0, BUSY=0, RELEASE_LINE=1; FSM->IDLE.
//  Reset mid-transfer aborts immediately; no further bytes are sent.
//  Commands, accepted only in IDLE: 0x46 'F' full frame (step 1); 0x48 'H' decimated (step 2, lines and columns).
//  Other bytes, and any byte while BUSY=1, are ignored with no state change.
//  FSM: IDLE -> HDR0 (send 0xA5) -> HDR1 (send 0x5A) -> WAIT_LINE -> FETCH -> SEND -> [CKSUM] -> NEXT_LINE.
//  Byte send: in a send state, wait TX_IDLE=1; then set TX_DATA and pulse TX_DATA_READY for exactly 1 cycle.
//  After each pulse: 1 guard cycle ignoring TX_IDLE, then wait for TX_IDLE=1 again. No strobe while TX_IDLE=0.
//  WAIT_LINE: hold until LINE_READY=1. RELEASE_LINE=0 from HDR0 until end of line.
//  FETCH: 1 cycle for PIXEL_DATA to settle at SELECTED_COLUMN; SEND transmits PIXEL_DATA.
//  After SEND: if SELECTED_COLUMN+step < H, advance column by step -> FETCH; else column=0 -> CKSUM/NEXT_LINE.
//  NEXT_LINE: RELEASE_LINE=1 for exactly 1 cycle. Then:
//   - if SELECTED_LINE+step < V: advance line by step -> WAIT_LINE.
//   - else: line=0 -> IDLE, BUSY=0, RELEASE_LINE held 1.
//  Sum compares are done at $clog2+1 bits; no wrap on odd H/V with step 2.
//  BUSY=1 from the cycle after an accepted command until return to IDLE.
//  LINE_READY dropping during SEND is ignored; the line finishes.
//  Bytes per frame: 2 + lines*(cols[+1]), with lines=ceil(V/step) and cols=ceil(H/step).
// CONFIGURATION
//  FRAME_READOUT_CKSUM_EN defined:
//   - 8-bit mod-256 sum of the line's pixel bytes is sent after the last pixel (CKSUM state).
//   - accumulator cleared on WAIT_LINE exit.
//  FRAME_READOUT_CKSUM_EN undefined: CKSUM state and accumulator absent; SEND goes straight to NEXT_LINE.
// STRUCTURE
//  Shared include frame_readout_defs.vh:
//   - command codes CMD_FULL=8'h46, CMD_HALF=8'h48
//   - header bytes HDR0=8'hA5, HDR1=8'h5A
//   - FSM state encodings
//  Sub-module tx_byte_gate: TX_IDLE wait, 1-cycle strobe, guard cycle; gives the FSM a byte_done pulse.
// TESTING (H=8, V=4, PIXEL_DATA=column index, TX_IDLE model busy 10 cycles/byte)
//  1. CMD 0x46, LINE_READY=1 -> 0xA5,0x5A, then 4x(00..07[,1C]); 34 bytes (38 with CKSUM_EN); BUSY falls; RELEASE_LINE pulses 4x.
//  2. CMD 0x48 -> header, lines 0,2, each 00,02,04,06[,0C]; 10 bytes (12 with CKSUM_EN).
//  3. LINE_READY=0 after header for 50 cycles -> no TX_DATA_READY pulses; transfer resumes after LINE_READY rises.
//  4. CMD 0x46 again mid-frame, and CMD 0x00 in IDLE -> ignored; byte count and order unchanged, BUSY stays 0 for 0x00.
//  5. RST on the 5th pixel of line 1 -> all outputs at reset values next cycle; a new 0x46 yields a complete 34/38-byte frame.
//  6. TX_IDLE held low 100 cycles mid-line -> no strobe while low; never two strobes within the guard window.

Source files
------------

// File: rtl/frame_readout_ctrl_pkg.sv
// Shared definitions for the frame readout controller: command codes, header bytes,
// FSM state encodings and small command-decode helpers.
package frame_readout_ctrl_pkg;

  localparam logic [7:0] CMD_FULL  = 8'h46;
  localparam logic [7:0] CMD_HALF  = 8'h48;
  localparam logic [7:0] HDR0_BYTE = 8'hA5;
  localparam logic [7:0] HDR1_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR0      = 3'd1,
    ST_HDR1      = 3'd2,
    ST_WAIT_LINE = 3'd3,
    ST_FETCH     = 3'd4,
    ST_SEND      = 3'd5,
    ST_CKSUM     = 3'd6,
    ST_NEXT_LINE = 3'd7
  } state_t;

  typedef enum logic {
    GATE_READY = 1'b0,
    GATE_GUARD = 1'b1
  } gate_state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_FULL) || (b == CMD_HALF);
  endfunction

  function automatic logic [1:0] cmd_step(input logic [7:0] b);
    return (b == CMD_HALF) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/frame_readout_ctrl_if.sv
// Command, line-buffer and uart_send signal bundle around the frame readout controller.
interface frame_readout_ctrl_if #(
  parameter int unsigned H = 752,
  parameter int unsigned V = 480
);
  localparam int unsigned CW = $clog2(H);
  localparam int unsigned LW = $clog2(V);

  logic [7:0]    CMD_DATA;
  logic          CMD_VALID;
  logic          LINE_READY;
  logic [7:0]    PIXEL_DATA;
  logic          TX_IDLE;
  logic [LW-1:0] SELECTED_LINE;
  logic [CW-1:0] SELECTED_COLUMN;
  logic          RELEASE_LINE;
  logic [7:0]    TX_DATA;
  logic          TX_DATA_READY;
  logic          BUSY;

  modport master (
    input  CMD_DATA, CMD_VALID, LINE_READY, PIXEL_DATA, TX_IDLE,
    output SELECTED_LINE, SELECTED_COLUMN, RELEASE_LINE, TX_DATA, TX_DATA_READY, BUSY
  );

  modport slave (
    output CMD_DATA, CMD_VALID, LINE_READY, PIXEL_DATA, TX_IDLE,
    input  SELECTED_LINE, SELECTED_COLUMN, RELEASE_LINE, TX_DATA, TX_DATA_READY, BUSY
  );
endinterface

// File: rtl/frame_readout_ctrl_tx_byte_gate.sv
// Byte gate towards uart_send: waits for TX_IDLE, emits a 1-cycle strobe with the byte,
// then holds off one guard cycle so a stale TX_IDLE cannot trigger a second strobe.
module tx_byte_gate
  import frame_readout_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send_req,
  input  logic [7:0] send_byte,
  input  logic       tx_idle,
  output logic [7:0] tx_data,
  output logic       tx_data_ready,
  output logic       byte_done
);

  gate_state_t gstate;

  always_ff @(posedge clk) begin
    if (rst) begin
      gstate        <= GATE_READY;
      tx_data       <= 8'h00;
      tx_data_ready <= 1'b0;
      byte_done     <= 1'b0;
    end else begin
      tx_data_ready <= 1'b0;
      byte_done     <= 1'b0;
      case (gstate)
        GATE_READY: begin
          if (send_req && tx_idle) begin
            tx_data       <= send_byte;
            tx_data_ready <= 1'b1;
            byte_done     <= 1'b1;
            gstate        <= GATE_GUARD;
          end
        end
        GATE_GUARD: gstate <= GATE_READY;
        default:    gstate <= GATE_READY;
      endcase
    end
  end

endmodule

// File: rtl/frame_readout_ctrl.sv
// Frame readout sequencer: header, then each line's pixels (full or 2x2-decimated).
// Define FRAME_READOUT_CKSUM_EN to append an 8-bit per-line checksum byte.
module frame_readout_ctrl
  import frame_readout_ctrl_pkg::*;
#(
  parameter int unsigned H = 752,
  parameter int unsigned V = 480
) (
  input  logic                 CLK,
  input  logic                 RST,
  frame_readout_ctrl_if.master bus
);

  localparam int unsigned CW  = $clog2(H);
  localparam int unsigned LW  = $clog2(V);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned LW1 = LW + 1;

  state_t        state;
  logic [1:0]    step;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic          release_line;
  logic          busy;
  logic          byte_done;
  logic          send_req_c;
  logic [7:0]    send_byte_c;
  logic [CW1-1:0] col_next_c;
  logic [LW1-1:0] line_next_c;
  logic           col_more_c;
  logic           line_more_c;
`ifdef FRAME_READOUT_CKSUM_EN
  logic [7:0]    cksum;
`endif

  // Extra bit keeps odd H/V with step 2 from wrapping past the end
  assign col_next_c  = {1'b0, col} + CW1'(step);
  assign line_next_c = {1'b0, line} + LW1'(step);
  assign col_more_c  = col_next_c < CW1'(H);
  assign line_more_c = line_next_c < LW1'(V);

  always_comb begin
    send_req_c  = 1'b0;
    send_byte_c = 8'h00;
    case (state)
      ST_HDR0: begin send_req_c = 1'b1; send_byte_c = HDR0_BYTE;      end
      ST_HDR1: begin send_req_c = 1'b1; send_byte_c = HDR1_BYTE;      end
      ST_SEND: begin send_req_c = 1'b1; send_byte_c = bus.PIXEL_DATA; end
`ifdef FRAME_READOUT_CKSUM_EN
      ST_CKSUM: begin send_req_c = 1'b1; send_byte_c = cksum;         end
`endif
      default: ;
    endcase
  end

  tx_byte_gate u_gate (
    .clk           (CLK),
    .rst           (RST),
    .send_req      (send_req_c),
    .send_byte     (send_byte_c),
    .tx_idle       (bus.TX_IDLE),
    .tx_data       (bus.TX_DATA),
    .tx_data_ready (bus.TX_DATA_READY),
    .byte_done     (byte_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      step         <= 2'd1;
      col          <= '0;
      line         <= '0;
      release_line <= 1'b1;
      busy         <= 1'b0;
`ifdef FRAME_READOUT_CKSUM_EN
      cksum        <= 8'h00;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.CMD_VALID && is_cmd(bus.CMD_DATA)) begin
            step         <= cmd_step(bus.CMD_DATA);
            busy         <= 1'b1;
            release_line <= 1'b0;
            state        <= ST_HDR0;
          end
        end
        ST_HDR0: if (byte_done) state <= ST_HDR1;
        ST_HDR1: if (byte_done) state <= ST_WAIT_LINE;
        ST_WAIT_LINE: begin
          if (bus.LINE_READY) begin
`ifdef FRAME_READOUT_CKSUM_EN
            cksum <= 8'h00;
`endif
            state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_SEND;
        ST_SEND: begin
          if (byte_done) begin
`ifdef FRAME_READOUT_CKSUM_EN
            cksum <= cksum + bus.TX_DATA;
`endif
            if (col_more_c) begin
              col   <= col_next_c[CW-1:0];
              state <= ST_FETCH;
            end else begin
              col <= '0;
`ifdef FRAME_READOUT_CKSUM_EN
              state <= ST_CKSUM;
`else
              release_line <= 1'b1;
              state        <= ST_NEXT_LINE;
`endif
            end
          end
        end
`ifdef FRAME_READOUT_CKSUM_EN
        ST_CKSUM: begin
          if (byte_done) begin
            release_line <= 1'b1;
            state        <= ST_NEXT_LINE;
          end
        end
`endif
        ST_NEXT_LINE: begin
          if (line_more_c) begin
            line         <= line_next_c[LW-1:0];
            release_line <= 1'b0;
            state        <= ST_WAIT_LINE;
          end else begin
            line  <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SELECTED_LINE   = line;
  assign bus.SELECTED_COLUMN = col;
  assign bus.RELEASE_LINE    = release_line;
  assign bus.BUSY            = busy;

endmodule

// File: tb/tb_frame_readout_ctrl.sv
// Bench for frame_readout_ctrl: H=8, V=4, pixel = column index, uart_send busy 10 cycles per byte.
module tb_frame_readout_ctrl;

  localparam int H       = 8;
  localparam int V       = 4;
  localparam int TX_BUSY = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int checks = 0;
  int errors = 0;
  bit cksum_en;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int  tx_cnt       = 0;
  bit  tx_hold      = 1'b0;
  int  rel_pulses   = 0;
  int  viol         = 0;
  int  since_strobe = 100;
  logic idle_at_edge = 1'b1;

  frame_readout_ctrl_if #(.H(H), .V(V)) bus ();

  frame_readout_ctrl #(.H(H), .V(V)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Line buffer: synchronous read; uart_send: busy for TX_BUSY cycles after each strobe
  assign bus.TX_IDLE = (tx_cnt == 0) && !tx_hold;
  always @(posedge CLK) begin
    bus.PIXEL_DATA <= 8'(bus.SELECTED_COLUMN);
    idle_at_edge   <= bus.TX_IDLE;
    if (bus.TX_DATA_READY) tx_cnt <= TX_BUSY;
    else if (tx_cnt > 0)   tx_cnt <= tx_cnt - 1;
  end

  always @(negedge CLK) begin
    if (bus.TX_DATA_READY) begin
      rx_q.push_back(bus.TX_DATA);
      if (!idle_at_edge || since_strobe == 0) viol++;
      since_strobe = 0;
    end else if (since_strobe < 1000) begin
      since_strobe++;
    end
    if (bus.RELEASE_LINE && bus.BUSY) rel_pulses++;
  end

  // Reference: header, then for every sent line each sent column's byte, plus optional sum
  function automatic void build_exp(input int stp);
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int l = 0; l < V; l += stp) begin
      s = 8'h00;
      for (int c = 0; c < H; c += stp) begin
        exp_q.push_back(8'(c));
        s = s + 8'(c);
      end
      if (cksum_en) exp_q.push_back(s);
    end
  endfunction

  function automatic int first_diff();
    int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
    if (rx_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    rel_pulses = 0;
    viol = 0;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge CLK);
    bus.CMD_DATA  = b;
    bus.CMD_VALID = 1'b1;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready, output bit timeout);
    int n = 0;
    while (bus.BUSY && n < budget) begin
      @(negedge CLK);
      if (rnd_ready) bus.LINE_READY = ($urandom_range(0, 3) != 0);
      n++;
    end
    bus.LINE_READY = 1'b1;
    timeout = bus.BUSY;
  endtask

  task automatic wait_bytes(input int nb, input int budget, output bit timeout);
    int n = 0;
    while (rx_q.size() < nb && n < budget) begin
      @(negedge CLK);
      n++;
    end
    timeout = (rx_q.size() < nb);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(3);
    checks++; if (bus.SELECTED_LINE !== 2'd0) begin errors++; $display("FAIL reset_line: got %0d expected 0", bus.SELECTED_LINE); end
    checks++; if (bus.SELECTED_COLUMN !== 3'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", bus.SELECTED_COLUMN); end
    checks++; if (bus.TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h expected 00", bus.TX_DATA); end
    checks++; if (bus.TX_DATA_READY !== 1'b0) begin errors++; $display("FAIL reset_txready: got %b expected 0", bus.TX_DATA_READY); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.RELEASE_LINE !== 1'b1) begin errors++; $display("FAIL reset_release: got %b expected 1", bus.RELEASE_LINE); end
    RST = 1'b0;
    tick(2);
  endtask

  task automatic test_frame(input logic [7:0] cmd, input int stp, input int exp_bytes);
    bit to;
    int d;
    clear_obs();
    bus.LINE_READY = 1'b1;
    send_cmd(cmd);
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL frame_busy_rise cmd=%h: got %b expected 1", cmd, bus.BUSY); end
    wait_done(5000, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL frame_timeout cmd=%h: BUSY still 1 expected 0", cmd); end
    build_exp(stp);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL frame_bytes cmd=%h: first diff at %0d, got %0d bytes expected %0d", cmd, d, rx_q.size(), exp_q.size()); end
    checks++; if (rx_q.size() != exp_bytes) begin errors++; $display("FAIL frame_count cmd=%h: got %0d expected %0d", cmd, rx_q.size(), exp_bytes); end
    checks++; if (rel_pulses != (V + stp - 1) / stp) begin errors++; $display("FAIL frame_release cmd=%h: got %0d pulses expected %0d", cmd, rel_pulses, (V + stp - 1) / stp); end
    checks++; if (bus.RELEASE_LINE !== 1'b1) begin errors++; $display("FAIL frame_release_idle: got %b expected 1", bus.RELEASE_LINE); end
    checks++; if (viol != 0) begin errors++; $display("FAIL frame_strobe_rule cmd=%h: got %0d violations expected 0", cmd, viol); end
  endtask

  task automatic test_line_stall();
    bit to;
    int d;
    clear_obs();
    bus.LINE_READY = 1'b0;
    send_cmd(8'h46);
    wait_bytes(2, 500, to);
    checks++; if (to) begin errors++; $display("FAIL stall_header_timeout: got %0d bytes expected 2", rx_q.size()); end
    tick(50);
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL stall_no_tx: got %0d bytes expected 2", rx_q.size()); end
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", bus.BUSY); end
    checks++; if (bus.RELEASE_LINE !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", bus.RELEASE_LINE); end
    bus.LINE_READY = 1'b1;
    wait_done(5000, 1'b0, to);
    build_exp(1);
    d = first_diff();
    checks++; if (to || d != -1) begin errors++; $display("FAIL stall_resume: timeout %0d first diff %0d expected -1", to, d); end
  endtask

  task automatic test_ignored_cmds();
    bit to;
    bit seen_busy = 1'b0;
    int d;
    logic [7:0] b;
    clear_obs();
    send_cmd(8'h00);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h46 || b == 8'h48) b = b ^ 8'h01;
      send_cmd(b);
      if (bus.BUSY) seen_busy = 1'b1;
    end
    tick(5);
    if (bus.BUSY) seen_busy = 1'b1;
    checks++; if (seen_busy) begin errors++; $display("FAIL ignore_busy: got 1 expected 0"); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL ignore_tx: got %0d bytes expected 0", rx_q.size()); end
    send_cmd(8'h46);
    wait_bytes(10, 1000, to);
    send_cmd(8'h48);
    send_cmd(8'h46);
    wait_done(5000, 1'b0, to);
    build_exp(1);
    d = first_diff();
    checks++; if (to || d != -1) begin errors++; $display("FAIL ignore_midframe: timeout %0d first diff %0d, got %0d bytes expected %0d", to, d, rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int d;
    int sz;
    clear_obs();
    bus.LINE_READY = 1'b1;
    send_cmd(8'h46);
    wait_bytes(2 + H + (cksum_en ? 1 : 0) + 5, 2000, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_reach: got %0d bytes", rx_q.size()); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (bus.BUSY !== 1'b0 || bus.TX_DATA_READY !== 1'b0 || bus.TX_DATA !== 8'h00) begin errors++; $display("FAIL rstmid_tx: busy %b ready %b data %h expected 0 0 00", bus.BUSY, bus.TX_DATA_READY, bus.TX_DATA); end
    checks++; if (bus.SELECTED_LINE !== 2'd0 || bus.SELECTED_COLUMN !== 3'd0 || bus.RELEASE_LINE !== 1'b1) begin errors++; $display("FAIL rstmid_lb: line %0d col %0d release %b expected 0 0 1", bus.SELECTED_LINE, bus.SELECTED_COLUMN, bus.RELEASE_LINE); end
    RST = 1'b0;
    sz = rx_q.size();
    tick(40);
    checks++; if (rx_q.size() != sz) begin errors++; $display("FAIL rstmid_silent: got %0d bytes expected %0d", rx_q.size(), sz); end
    clear_obs();
    send_cmd(8'h46);
    wait_done(5000, 1'b0, to);
    build_exp(1);
    d = first_diff();
    checks++; if (to || d != -1) begin errors++; $display("FAIL rstmid_newframe: timeout %0d first diff %0d, got %0d bytes expected %0d", to, d, rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_tx_stall();
    bit to;
    int d;
    int sz;
    clear_obs();
    send_cmd(8'h46);
    wait_bytes(5, 1000, to);
    tx_hold = 1'b1;
    sz = rx_q.size();
    tick(100);
    checks++; if (rx_q.size() != sz) begin errors++; $display("FAIL txstall_no_strobe: got %0d bytes expected %0d", rx_q.size(), sz); end
    tx_hold = 1'b0;
    wait_done(5000, 1'b0, to);
    build_exp(1);
    d = first_diff();
    checks++; if (to || d != -1) begin errors++; $display("FAIL txstall_frame: timeout %0d first diff %0d", to, d); end
    checks++; if (viol != 0) begin errors++; $display("FAIL txstall_strobe_rule: got %0d violations expected 0", viol); end
  endtask

  task automatic test_random_frames();
    bit to;
    int d;
    int stp;
    for (int k = 0; k < 4; k++) begin
      stp = $urandom_range(1, 2);
      clear_obs();
      send_cmd(stp == 2 ? 8'h48 : 8'h46);
      wait_done(20000, 1'b1, to);
      build_exp(stp);
      d = first_diff();
      checks++; if (to || d != -1) begin errors++; $display("FAIL random_frame%0d step %0d: timeout %0d first diff %0d", k, stp, to, d); end
      checks++; if (rel_pulses != (V + stp - 1) / stp) begin errors++; $display("FAIL random_release%0d: got %0d expected %0d", k, rel_pulses, (V + stp - 1) / stp); end
    end
  endtask

  initial begin
`ifdef FRAME_READOUT_CKSUM_EN
    cksum_en = 1'b1;
`else
    cksum_en = 1'b0;
`endif
    bus.CMD_DATA   = 8'h00;
    bus.CMD_VALID  = 1'b0;
    bus.LINE_READY = 1'b1;
    test_reset();
    test_frame(8'h46, 1, cksum_en ? 38 : 34);
    test_frame(8'h48, 2, cksum_en ? 12 : 10);
    test_line_stall();
    test_ignored_cmds();
    test_reset_mid();
    test_tx_stall();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
